// File: rtl/chess_mem_arbiter_if.sv
// Bundle of renderer, processor and board-RAM signals around the arbiter.
// Latency: none; this file only carries wires.
// Backpressure: the arbiter stalls the CPU by delaying cpu_ack; the VGA side sees vga_stall.
interface chess_mem_arbiter_if;
   // renderer side
   logic        vga_req;
   logic [11:0] vga_addr;
   logic [31:0] vga_data;
   logic        vga_stall;
   // processor side
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   // board RAM side
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // arbiter view
   modport slave (
      input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vga_data, vga_stall, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );

   // client and RAM view
   modport master (
      output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vga_data, vga_stall, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/chess_mem_arbiter.sv
// Shares the single-port board RAM between the VGA renderer (priority) and the game CPU.
// Latency: VGA 1 cycle like raw RAM; CPU ack 2 cycles in blanking, at most STARVE_LIMIT+2 in active video.
// Backpressure: CPU waits for cpu_ack; one stolen renderer slot per access, flagged by vga_stall.
module chess_mem_arbiter #(
   parameter int STARVE_LIMIT = 16   // usable range 1..255 (8-bit wait counter)
) (
   input logic              iCLK,
   input logic              iRST,
   chess_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, ACC, RESP} state_t;

   localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  starve_cnt;
   logic [7:0]  starve_cnt_d;
   logic        owner_q;      // 1 = CPU owned the port last cycle
   logic        vga_req_q;
   logic [31:0] hold_q;       // last word shown to the renderer
   logic        cpu_own;
   logic [31:0] vga_data_w;

   // state register plus the per-cycle history used to mask a stolen slot
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q    <= IDLE;
         starve_cnt <= 8'd0;
         owner_q    <= 1'b0;
         vga_req_q  <= 1'b0;
         hold_q     <= 32'd0;
      end else begin
         state_q    <= state_d;
         starve_cnt <= starve_cnt_d;
         owner_q    <= cpu_own;
         vga_req_q  <= bus.vga_req;
         hold_q     <= vga_data_w;
      end
   end

   // next state: blanking goes straight to ACC, active video waits out the starve counter
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               if (bus.vga_req) begin
                  state_d      = WAIT;
                  starve_cnt_d = 8'd0;
               end else begin
                  state_d = ACC;
               end
            end
         end
         WAIT: begin
            // a vga_req drop coinciding with the limit is one transition, not two
            if (!bus.vga_req || starve_cnt == LIMIT_M1) begin
               state_d = ACC;
            end else begin
               starve_cnt_d = starve_cnt + 8'd1;
            end
         end
         ACC:     state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs: CPU owns the RAM only in ACC, and reset kills both the write strobe and the ack
   always_comb begin
      cpu_own       = (state_q == ACC) && !iRST;
      bus.mem_addr  = cpu_own ? bus.cpu_addr : bus.vga_addr;
      bus.mem_we    = cpu_own & bus.cpu_we;
      bus.mem_wdata = bus.cpu_wdata;
      bus.cpu_ack   = (state_q == RESP) && !iRST;
      bus.cpu_rdata = bus.cpu_ack ? bus.mem_rdata : 32'd0;
      // RAM output after a CPU cycle belongs to the CPU, so replay the previous word
      vga_data_w    = owner_q ? hold_q : bus.mem_rdata;
      bus.vga_data  = vga_data_w;
      bus.vga_stall = owner_q & vga_req_q;
   end

endmodule

// File: tb/tb_chess_mem_arbiter.sv
// Bench for chess_mem_arbiter: directed CPU/VGA sequences with scoreboard queues.
// Latency expectations are hand-computed per vector and checked by a separate monitor.
// Backpressure: CPU driver holds cpu_req until ack (bounded wait).
module tb_chess_mem_arbiter;

   localparam int LIMIT = 4;

   logic iCLK = 1'b0;
   logic iRST = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   fails = 0;

   chess_mem_arbiter_if bus();

   chess_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (bus)
   );

   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        stall;
   } vexp_t;

   typedef struct {
      int          acc_cyc;
      int          ack_cyc;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        stall;
      logic        ack;
   } cexp_t;

   vexp_t vgaq[$];
   cexp_t cpuq[$];

   logic [31:0] ram [0:4095];
   logic [31:0] exp_mem [0:4095];

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'h0000_001D;
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i]     = init_word(i);
         exp_mem[i] = init_word(i);
      end
   end

   // board RAM: synchronous read, one cycle latency, read-before-write
   always @(posedge iCLK) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // monitor: pops expectations when the DUT presents data or an ack
   always @(negedge iCLK) begin
      vexp_t mv;
      cexp_t mc;
      logic  we_ok;
      we_ok = 1'b0;
      if (vgaq.size() > 0 && vgaq[0].cyc == cyc) begin
         mv = vgaq.pop_front();
         check("vga_data", bus.vga_data, mv.data);
         check("vga_stall", 32'(bus.vga_stall), 32'(mv.stall));
      end
      if (cpuq.size() > 0) begin
         if (cyc == cpuq[0].acc_cyc) begin
            we_ok = cpuq[0].we;
            check("acc_mem_addr", 32'(bus.mem_addr), 32'(cpuq[0].addr));
            check("acc_mem_we", 32'(bus.mem_we), 32'(cpuq[0].we));
            if (cpuq[0].we) check("acc_mem_wdata", bus.mem_wdata, cpuq[0].wdata);
         end
         if (bus.cpu_ack || cyc >= cpuq[0].ack_cyc) begin
            mc = cpuq.pop_front();
            check("cpu_ack", 32'(bus.cpu_ack), 32'(mc.ack));
            if (bus.cpu_ack) begin
               check("ack_cycle", 32'(cyc), 32'(mc.ack_cyc));
               if (!mc.we) check("cpu_rdata", bus.cpu_rdata, mc.rdata);
               check("ack_vga_stall", 32'(bus.vga_stall), 32'(mc.stall));
            end
         end
      end else if (bus.cpu_ack) begin
         vectors++;
         fails++;
         $display("FAIL unexpected_ack: got 1 want 0 (cycle %0d)", cyc);
      end
      if (bus.mem_we && !we_ok) begin
         vectors++;
         fails++;
         $display("FAIL unexpected_mem_we: got 1 want 0 (cycle %0d)", cyc);
      end
   end

   // issue one CPU access; acc_lat is the hand-computed issue-to-ACC distance
   task automatic cpu_xfer(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                           input int acc_lat, input logic stall);
      cexp_t e;
      bit    got;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
      e.acc_cyc = cyc + acc_lat;
      e.ack_cyc = cyc + acc_lat + 1;
      e.we      = we;
      e.addr    = addr;
      e.wdata   = wd;
      e.rdata   = exp_mem[addr];
      e.stall   = stall;
      e.ack     = 1'b1;
      cpuq.push_back(e);
      if (we) exp_mem[addr] = wd;
      got = 0;
      for (int t = 0; t < LIMIT + 20 && !got; t++) begin
         @(negedge iCLK);
         if (bus.cpu_ack) got = 1;
      end
      if (!got) begin
         vectors++;
         fails++;
         $display("FAIL cpu_ack_timeout: got 0 want 1 (cycle %0d)", cyc);
      end
      @(posedge iCLK);
      #1;
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
   endtask

   // renderer streams addresses 0..n-1; the slot at steal_cyc shows the held word
   task automatic vga_stream(input int n, input int steal_cyc);
      vexp_t e;
      for (int i = 0; i < n; i++) begin
         bus.vga_req  = 1'b1;
         bus.vga_addr = 12'(i);
         e.cyc = cyc + 1;
         if (cyc == steal_cyc) begin
            e.data  = exp_mem[i - 1];
            e.stall = 1'b1;
         end else begin
            e.data  = exp_mem[i];
            e.stall = 1'b0;
         end
         vgaq.push_back(e);
         @(posedge iCLK);
         #1;
      end
      bus.vga_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      bus.vga_req   = 1'b0;
      bus.vga_addr  = 12'h123;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 12'h077;
      bus.cpu_wdata = 32'd0;

      // reset held 3 cycles with a pending CPU read
      repeat (3) begin
         @(posedge iCLK);
         @(negedge iCLK);
         check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
         check("rst_mem_we", 32'(bus.mem_we), 32'd0);
         check("rst_mem_addr", 32'(bus.mem_addr), 32'h123);
         check("rst_vga_stall", 32'(bus.vga_stall), 32'd0);
      end
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      cpu_xfer(1'b0, 12'h077, 32'd0, 1, 1'b0);

      // blanking write then read-back
      cpu_xfer(1'b1, 12'd12, 32'h0000_002B, 1, 1'b0);
      @(negedge iCLK);
      check("post_ack_mem_we", 32'(bus.mem_we), 32'd0);
      @(posedge iCLK);
      #1;
      cpu_xfer(1'b0, 12'd12, 32'd0, 1, 1'b0);
      repeat (2) @(posedge iCLK);
      #1;

      // active video: CPU read of 5 steals a slot after LIMIT wait cycles
      base = cyc;
      fork
         vga_stream(64, base + 2 + LIMIT + 1);
         begin
            repeat (2) begin
               @(posedge iCLK);
               #1;
            end
            cpu_xfer(1'b0, 12'd5, 32'd0, LIMIT + 1, 1'b1);
         end
      join
      repeat (3) @(posedge iCLK);
      #1;

      // vga_req drops while waiting: ACC 3 cycles after issue, no stall
      fork
         vga_stream(6, -1);
         begin
            repeat (4) begin
               @(posedge iCLK);
               #1;
            end
            cpu_xfer(1'b0, 12'h021, 32'd0, 3, 1'b0);
         end
      join
      repeat (3) @(posedge iCLK);
      #1;

      // plain streaming with no CPU traffic
      vga_stream(67, -1);
      repeat (2) @(posedge iCLK);
      #1;

      // reset lands right after the ACC edge of a write: data kept, ack suppressed
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 12'd66;
      bus.cpu_wdata = 32'hFACE_0066;
      begin
         cexp_t e;
         e.acc_cyc = cyc + 1;
         e.ack_cyc = cyc + 2;
         e.we      = 1'b1;
         e.addr    = 12'd66;
         e.wdata   = 32'hFACE_0066;
         e.rdata   = 32'd0;
         e.stall   = 1'b0;
         e.ack     = 1'b0;
         cpuq.push_back(e);
      end
      exp_mem[66] = 32'hFACE_0066;
      @(posedge iCLK);
      #1;
      @(posedge iCLK);
      #1;
      iRST         = 1'b1;
      bus.cpu_req  = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.vga_addr = 12'h3C0;
      @(negedge iCLK);
      check("abort_mem_we", 32'(bus.mem_we), 32'd0);
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
      @(negedge iCLK);
      check("abort_mem_addr", 32'(bus.mem_addr), 32'h3C0);
      check("abort_no_ack", 32'(bus.cpu_ack), 32'd0);
      @(posedge iCLK);
      #1;
      cpu_xfer(1'b0, 12'd66, 32'd0, 1, 1'b0);

      repeat (4) @(posedge iCLK);
      #1;
      check("cpu_queue_drained", 32'(cpuq.size()), 32'd0);
      check("vga_queue_drained", 32'(vgaq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
